// File: rtl/adder_tv_writer.sv
// Captures observed adder tuples {a, b, c_in, s, c_out} into a first-word-fall-through
// record buffer, with optional suppression of repeats and a sticky overflow flag.
module adder_tv_writer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cap_en,
  input  logic                     dedup,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     c_in,
  input  logic [WIDTH-1:0]         s,
  input  logic                     c_out,
  output logic [3*WIDTH+1:0]       rec_data,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int TW = 3*WIDTH+2;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [TW-1:0] mem_q [DEPTH];
  logic [TW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          have_last_q, have_last_d;
  logic [TW-1:0] last_tuple_q, last_tuple_d;

  logic [TW-1:0] tuple;
  logic          qualified;
  logic          pop;
  logic          accept;
  logic          drop;

  assign tuple     = {a, b, c_in, s, c_out};
  assign qualified = cap_en && !(dedup && have_last_q && (tuple == last_tuple_q));
  assign pop       = (count_q != '0) && rec_ready;
  // When full, a same-edge pop frees the head slot, which is exactly the tail slot.
  assign accept    = qualified && ((count_q < FULL) || pop);
  assign drop      = qualified && !accept;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    have_last_d  = have_last_q;
    last_tuple_d = last_tuple_q;

    if (accept) begin
      mem_d[wr_ptr_q] = tuple;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      have_last_d     = 1'b1;
      last_tuple_d    = tuple;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // A drop on the same edge as a clear request leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      have_last_q  <= 1'b0;
      last_tuple_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      have_last_q  <= have_last_d;
      last_tuple_q <= last_tuple_d;
    end
  end

  assign rec_data  = mem_q[rd_ptr_q];
  assign rec_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder_tv_writer.sv
// Randomized and directed bench for adder_tv_writer against a queue-based record model.
module tb_adder_tv_writer;

  localparam int WIDTH = 2;
  localparam int DEPTH = 8;
  localparam int TW    = 3*WIDTH+2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             cap_en = 1'b0;
  logic             dedup = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic [WIDTH-1:0] s = '0;
  logic             c_out = 1'b0;
  logic [TW-1:0]    rec_data;
  logic             rec_valid;
  logic             rec_ready = 1'b0;
  logic [3:0]       count;
  logic             overflow;
  logic             clear_ovf = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [TW-1:0] m_q[$];
  bit            m_have;
  logic [TW-1:0] m_last;
  bit            m_ovf;

  adder_tv_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cap_en(cap_en), .dedup(dedup),
    .a(a), .b(b), .c_in(c_in), .s(s), .c_out(c_out),
    .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .count(count), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic set_tuple(input int k);
    logic [TW-1:0] t;
    t = TW'(k);
    {a, b, c_in, s, c_out} = t;
  endtask

  // Advance one clock edge, updating the record model from the current inputs.
  task automatic tick();
    logic [TW-1:0] t;
    bit qual, pop, acc;
    t    = {a, b, c_in, s, c_out};
    qual = cap_en && !(dedup && m_have && (t == m_last));
    pop  = rec_ready && (m_q.size() != 0);
    acc  = qual && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(t);
      m_have = 1'b1;
      m_last = t;
    end
    if (qual && !acc) m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    cap_en = 1'b0; rec_ready = 1'b0; dedup = 1'b0; clear_ovf = 1'b0;
    set_tuple(0);
    m_q.delete(); m_have = 1'b0; m_last = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (rec_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || rec_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset: valid=%b count=%0d ovf=%b data=%h required 0 0 0 00",
               rec_valid, count, overflow, rec_data);
    end
  endtask

  task automatic test_single();
    apply_reset();
    cap_en = 1'b1; rec_ready = 1'b0;
    a = 2'd2; b = 2'd3; c_in = 1'b1; s = 2'd2; c_out = 1'b1;
    tick();
    cap_en = 1'b0;
    n_vec++;
    if (rec_valid !== 1'b1 || rec_data !== 8'b10_11_1_10_1 || count !== 4'd1) begin
      n_err++;
      $display("FAIL single_capture: valid=%b data=%b count=%0d required 1 10111101 1",
               rec_valid, rec_data, count);
    end
  endtask

  task automatic test_exhaustive();
    logic [TW-1:0] got[$];
    int ai, bi, ci, sm;
    logic [TW-1:0] expv;
    apply_reset();
    rec_ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      cap_en = (i < 32);
      ai = (i >> 3) & 3; bi = (i >> 1) & 3; ci = i & 1; sm = ai + bi + ci;
      a = WIDTH'(ai); b = WIDTH'(bi); c_in = ci[0]; s = WIDTH'(sm & 3); c_out = sm[2];
      if (rec_valid && rec_ready) got.push_back(rec_data);
      tick();
      n_vec++;
      if (count > 4'd1 || overflow !== 1'b0 || count !== 4'(m_q.size())) begin
        n_err++;
        $display("FAIL exhaustive_state: cycle %0d count=%0d ovf=%b required count=%0d ovf=0",
                 i, count, overflow, m_q.size());
      end
    end
    n_vec++;
    if (got.size() != 32) begin
      n_err++;
      $display("FAIL exhaustive_len: got %0d records required 32", got.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        ai = (i >> 3) & 3; bi = (i >> 1) & 3; ci = i & 1; sm = ai + bi + ci;
        expv = TW'((ai << 6) | (bi << 4) | (ci << 3) | ((sm & 3) << 1) | (sm >> 2));
        n_vec++;
        if (got[i] !== expv) begin
          n_err++;
          $display("FAIL exhaustive_rec %0d: got %b required %b", i, got[i], expv);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [TW-1:0] tv[9];
    apply_reset();
    rec_ready = 1'b0; cap_en = 1'b1;
    for (int j = 0; j < 9; j++) begin
      tv[j] = TW'(16 + j * 7);
      set_tuple(16 + j * 7);
      tick();
    end
    cap_en = 1'b0;
    n_vec++;
    if (count !== 4'd8 || overflow !== 1'b1 || rec_data !== tv[0]) begin
      n_err++;
      $display("FAIL overflow_full: count=%0d ovf=%b head=%h required 8 1 %h",
               count, overflow, rec_data, tv[0]);
    end
    rec_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_vec++;
      if (rec_valid !== 1'b1 || rec_data !== tv[j]) begin
        n_err++;
        $display("FAIL overflow_pop %0d: valid=%b data=%h required 1 %h", j, rec_valid, rec_data, tv[j]);
      end
      tick();
    end
    n_vec++;
    if (rec_valid !== 1'b0 || count !== 4'd0) begin
      n_err++;
      $display("FAIL overflow_empty: valid=%b count=%0d required 0 0", rec_valid, count);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [TW-1:0] out[$];
    apply_reset();
    rec_ready = 1'b0; cap_en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      set_tuple(100 + j);
      tick();
    end
    set_tuple(200); rec_ready = 1'b1;
    tick();
    cap_en = 1'b0;
    n_vec++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_cap_pop: count=%0d ovf=%b required 8 0", count, overflow);
    end
    for (int j = 0; j < 8; j++) begin
      if (rec_valid) out.push_back(rec_data);
      tick();
    end
    n_vec++;
    if (out.size() != 8 || out[0] !== 8'd101 || out[7] !== 8'd200) begin
      n_err++;
      $display("FAIL full_order: n=%0d first=%0d last=%0d required 8 101 200",
               out.size(), (out.size() > 0) ? out[0] : 0, (out.size() > 7) ? out[7] : 0);
    end
  endtask

  task automatic test_dedup();
    apply_reset();
    rec_ready = 1'b0; cap_en = 1'b1; dedup = 1'b1;
    set_tuple(8'h5a);
    repeat (4) tick();
    set_tuple(8'h3c);
    tick();
    n_vec++;
    if (count !== 4'd2) begin
      n_err++;
      $display("FAIL dedup_on: count=%0d required 2", count);
    end
    dedup = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_vec++;
      if (count !== 4'(3 + j)) begin
        n_err++;
        $display("FAIL dedup_off %0d: count=%0d required %0d", j, count, 3 + j);
      end
    end
    cap_en = 1'b0;
  endtask

  task automatic test_clear_ovf();
    apply_reset();
    rec_ready = 1'b0; cap_en = 1'b1;
    for (int j = 0; j < 9; j++) begin
      set_tuple(j);
      tick();
    end
    set_tuple(77); clear_ovf = 1'b1;
    tick();
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clear_vs_drop: ovf=%b required 1", overflow);
    end
    cap_en = 1'b0;
    tick();
    clear_ovf = 1'b0;
    n_vec++;
    if (overflow !== 1'b0 || count !== 4'd8) begin
      n_err++;
      $display("FAIL clear_ovf: ovf=%b count=%0d required 0 8", overflow, count);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rec_ready = 1'b0; cap_en = 1'b1;
    for (int j = 0; j < 9; j++) begin
      set_tuple(40 + j);
      tick();
    end
    cap_en = 1'b0; rec_ready = 1'b1;
    repeat (3) tick();
    rec_ready = 1'b0;
    n_vec++;
    if (count !== 4'd5 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL async_setup: count=%0d ovf=%b required 5 1", count, overflow);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (rec_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || rec_data !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: valid=%b count=%0d ovf=%b data=%h required 0 0 0 00",
               rec_valid, count, overflow, rec_data);
    end
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cap_en    = ($urandom_range(0, 3) != 0);
      rec_ready = ($urandom_range(0, 2) == 0);
      dedup     = $urandom_range(0, 1);
      clear_ovf = ($urandom_range(0, 15) == 0);
      set_tuple($urandom_range(0, 3) * 37);
      tick();
      n_vec++;
      if (rec_valid !== (m_q.size() != 0) || count !== 4'(m_q.size()) || overflow !== m_ovf ||
          (m_q.size() != 0 && rec_data !== m_q[0])) begin
        n_err++;
        $display("FAIL random %0d: valid=%b count=%0d ovf=%b data=%h required %b %0d %b %h",
                 i, rec_valid, count, overflow, rec_data, m_q.size() != 0, m_q.size(), m_ovf,
                 (m_q.size() != 0) ? m_q[0] : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_exhaustive();
    test_overflow();
    test_full_simultaneous();
    test_dedup();
    test_clear_ovf();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
